uart_rx_fifo: RTL and testbench

//  Receive-side byte buffer placed directly downstream of the UART receiver.

---
 rtl/uart_rx_fifo_pkg.sv | 17 +
 rtl/fifo_mem_dp.sv | 43 ++++
 rtl/uart_rx_fifo.sv | 109 ++++++++++
 tb/tb_uart_rx_fifo.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared defaults and operation encoding for the UART receive FIFO
package uart_rx_fifo_pkg;

    localparam int DATA_BITS_DEF = 8;
    localparam int ADDR_BITS_DEF = 4;
    localparam int CLOCK_HZ      = 1_000_000;
    localparam int BAUD          = 100_000;

    // Encoded as {push, pop} so the enum can be built straight from the two enables.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_mem_dp.sv
// rtl/fifo_mem_dp.sv - simple dual-port byte RAM; async read when UART_RX_FIFO_FWFT_EN, registered read otherwise
module fifo_mem_dp #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk_i,
`ifndef UART_RX_FIFO_FWFT_EN
    input  logic                 rst_i,
    input  logic                 re_i,
`endif
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [DATA_BITS-1:0] wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [DATA_BITS-1:0] rdata_o
);

    logic [DATA_BITS-1:0] mem_q [2**ADDR_BITS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

`ifdef UART_RX_FIFO_FWFT_EN
    assign rdata_o = mem_q[raddr_i];
`else
    logic [DATA_BITS-1:0] rdata_q;

    // Reads the pre-write contents, so a pop and a push to the same slot return the old byte.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte FIFO behind the UART receiver; UART_RX_FIFO_FWFT_EN selects first-word-fall-through
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [DATA_BITS-1:0] WrData_i,
    input  logic                 WrStrobe_i,
    input  logic                 Read_i,
    output logic [DATA_BITS-1:0] Data_o,
    output logic                 ReadValid_o,
    output logic                 Empty_o,
    output logic                 Full_o,
    output logic [ADDR_BITS:0]   Count_o,
    output logic                 Overflow_o,
    input  logic                 ClearOverflow_i
);

    localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS + 1)'(2 ** ADDR_BITS);

    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic                 empty_q, empty_d;
    logic                 full_q, full_d;
    logic                 overflow_q, overflow_d;
    logic                 wr_en, rd_en, drop;
    fifo_op_e             op;

    always_comb begin
        rd_en = Read_i & ~empty_q;
        // A pop in the same cycle frees the slot a full buffer needs for the incoming byte.
        wr_en = WrStrobe_i & (~full_q | rd_en);
        drop  = WrStrobe_i & full_q & ~rd_en;
        op    = fifo_op_e'({wr_en, rd_en});

        count_d = count_q;
        unique case (op)
            OP_PUSH: count_d = count_q + 1'b1;
            OP_POP:  count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        empty_d    = (count_d == '0);
        full_d     = (count_d == DEPTH_CNT);
        overflow_d = drop ? 1'b1 : (ClearOverflow_i ? 1'b0 : overflow_q);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    fifo_mem_dp #(
        .ADDR_BITS(ADDR_BITS),
        .DATA_BITS(DATA_BITS)
    ) u_mem (
        .clk_i   (Clock),
`ifndef UART_RX_FIFO_FWFT_EN
        .rst_i   (Reset),
        .re_i    (rd_en),
`endif
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (WrData_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (Data_o)
    );

`ifdef UART_RX_FIFO_FWFT_EN
    assign ReadValid_o = ~empty_q;
`else
    logic rvalid_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_en;
        end
    end

    assign ReadValid_o = rvalid_q;
`endif

    assign Count_o    = count_q;
    assign Empty_o    = empty_q;
    assign Full_o     = full_q;
    assign Overflow_o = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed scoreboard bench for uart_rx_fifo (both UART_RX_FIFO_FWFT_EN modes)
module tb_uart_rx_fifo;
    import uart_rx_fifo_pkg::*;

    localparam int DEPTH    = 2 ** ADDR_BITS_DEF;
    localparam int BYTE_CYC = 10 * CLOCK_HZ / BAUD;

    logic                     Clock;
    logic                     Reset;
    logic [DATA_BITS_DEF-1:0] WrData_i;
    logic                     WrStrobe_i;
    logic                     Read_i;
    logic [DATA_BITS_DEF-1:0] Data_o;
    logic                     ReadValid_o;
    logic                     Empty_o;
    logic                     Full_o;
    logic [ADDR_BITS_DEF:0]   Count_o;
    logic                     Overflow_o;
    logic                     ClearOverflow_i;

    int checks = 0;
    int errors = 0;
    logic [DATA_BITS_DEF-1:0] sb[$];
    logic m_ov = 1'b0;

    uart_rx_fifo dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .WrData_i        (WrData_i),
        .WrStrobe_i      (WrStrobe_i),
        .Read_i          (Read_i),
        .Data_o          (Data_o),
        .ReadValid_o     (ReadValid_o),
        .Empty_o         (Empty_o),
        .Full_o          (Full_o),
        .Count_o         (Count_o),
        .Overflow_o      (Overflow_o),
        .ClearOverflow_i (ClearOverflow_i)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_count"}, 32'(Count_o), 32'(sb.size()));
        chk({tag, "_empty"}, 32'(Empty_o), 32'(sb.size() == 0));
        chk({tag, "_full"}, 32'(Full_o), 32'(sb.size() == DEPTH));
        chk({tag, "_ovf"}, 32'(Overflow_o), 32'(m_ov));
    endtask

    task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic clr,
                        input string tag);
        bit rd_ok, wr_ok, drop;
        logic [7:0] exp;
        rd_ok = rd && (sb.size() != 0);
        wr_ok = wr && ((sb.size() < DEPTH) || rd_ok);
        drop  = wr && !wr_ok;
        exp   = 8'h00;
        if (rd_ok) exp = sb[0];
`ifdef UART_RX_FIFO_FWFT_EN
        if (rd_ok) chk({tag, "_fwft_data"}, 32'(Data_o), 32'(exp));
`endif
        WrStrobe_i = wr; WrData_i = d; Read_i = rd; ClearOverflow_i = clr;
        @(posedge Clock); #1;
        WrStrobe_i = 1'b0; Read_i = 1'b0; ClearOverflow_i = 1'b0;
        if (rd_ok) void'(sb.pop_front());
        if (wr_ok) sb.push_back(d);
        if (drop) m_ov = 1'b1;
        else if (clr) m_ov = 1'b0;
`ifdef UART_RX_FIFO_FWFT_EN
        chk({tag, "_rvalid"}, 32'(ReadValid_o), 32'(sb.size() != 0));
`else
        chk({tag, "_rvalid"}, 32'(ReadValid_o), 32'(rd_ok));
        if (rd_ok) chk({tag, "_rdata"}, 32'(Data_o), 32'(exp));
`endif
        chk_flags(tag);
    endtask

    task automatic do_reset(input int cycles, input logic strobe);
        Reset = 1'b1; WrStrobe_i = strobe; WrData_i = 8'hA5;
        repeat (cycles) begin
            @(posedge Clock); #1;
        end
        Reset = 1'b0; WrStrobe_i = 1'b0;
        sb.delete();
        m_ov = 1'b0;
    endtask

    initial begin
        Reset = 1'b0; WrData_i = '0; WrStrobe_i = 1'b0; Read_i = 1'b0; ClearOverflow_i = 1'b0;
        @(posedge Clock); #1;

        // Reset state
        do_reset(2, 1'b0);
        chk_flags("reset");
        chk("reset_rvalid", 32'(ReadValid_o), 32'(0));
`ifndef UART_RX_FIFO_FWFT_EN
        chk("reset_data", 32'(Data_o), 32'(0));
`endif

        // Two bytes arriving one character time apart, then drained
        step(1'b1, 8'h55, 1'b0, 1'b0, "lb_w0");
        repeat (BYTE_CYC) @(posedge Clock);
        #1;
        step(1'b1, 8'hAA, 1'b0, 1'b0, "lb_w1");
        step(1'b0, 8'h00, 1'b1, 1'b0, "lb_r0");
        step(1'b0, 8'h00, 1'b1, 1'b0, "lb_r1");
        step(1'b0, 8'h00, 1'b0, 1'b0, "lb_idle");
        step(1'b0, 8'h00, 1'b1, 1'b0, "lb_rd_empty");

        // Fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        step(1'b1, 8'hFF, 1'b0, 1'b0, "drop");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        step(1'b0, 8'h00, 1'b0, 1'b1, "clr_ovf");

        // Pointer wrap-around
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, "wrap_w10");
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "wrap_r10");
        for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, "wrap_w12");
        for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "wrap_r12");

        // Simultaneous push and pop when full, then when empty
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, "sim_fill");
        step(1'b1, 8'h77, 1'b1, 1'b0, "sim_full_both");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "sim_drain");
        step(1'b1, 8'h88, 1'b1, 1'b0, "sim_empty_both");
        step(1'b0, 8'h00, 1'b1, 1'b0, "sim_pop88");

        // Overflow set-over-clear priority, clear alone, reset mid-stream
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "ov_fill");
        step(1'b1, 8'hEE, 1'b0, 1'b0, "ov_drop");
        step(1'b1, 8'hEF, 1'b0, 1'b1, "ov_clr_drop");
        step(1'b0, 8'h00, 1'b0, 1'b1, "ov_clr");
        for (int i = 0; i < DEPTH - 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "ov_pop");
        chk("mid_count5", 32'(Count_o), 32'(5));
        do_reset(1, 1'b1);
        chk_flags("mid_reset");
        step(1'b1, 8'h99, 1'b0, 1'b0, "post_reset_w");
        step(1'b0, 8'h00, 1'b1, 1'b0, "post_reset_r");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
